// File: rtl/poly_mul_load_sequencer_pkg.sv
// Shared types and constants for the polynomial-multiply BRAM load sequencer.
// Sizes are fixed for 256-coefficient polynomials packed into 64-bit BRAM words.
package poly_mul_load_sequencer_pkg;

  localparam int ADDR_W          = 8;
  localparam int S_WORDS         = 16;
  localparam int A_WORDS         = 52;
  localparam int BRAM_RD_LATENCY = 1;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_W = $clog2(max_i(S_WORDS, A_WORDS) + 1);

  typedef enum logic [2:0] {IDLE, LOAD_S, STREAM_A, DRAIN, DONE} state_e;

  typedef enum logic {PH_S, PH_A} phase_e;

  // Travels alongside a BRAM read so the returned word can be classified.
  typedef struct packed {
    logic   valid;
    phase_e phase;
    logic   last;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_NONE = '{valid: 1'b0, phase: PH_S, last: 1'b0};

endpackage

// File: rtl/poly_mul_load_sequencer_if.sv
// Handshake bundle between instruction decoder, BRAM read port and multiplier.
// master drives requests and backpressure; slave is the sequencer.
interface poly_mul_load_sequencer_if
  import poly_mul_load_sequencer_pkg::*;
();

  logic              start;
  logic [ADDR_W-1:0] s_base;
  logic [ADDR_W-1:0] a_base;
  logic              mul_ready;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_rd_en;
  logic              s_load_valid;
  logic              s_load_done;
  logic              a_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, s_base, a_base, mul_ready,
    input  bram_addr, bram_rd_en, s_load_valid, s_load_done, a_valid, busy, done
  );

  modport slave (
    input  start, s_base, a_base, mul_ready,
    output bram_addr, bram_rd_en, s_load_valid, s_load_done, a_valid, busy, done
  );

endinterface

// File: rtl/poly_mul_load_sequencer_bram_rd_valid_pipe.sv
// Delays the read-issue tag by the BRAM read latency so it lines up with dout.
module bram_rd_valid_pipe
  import poly_mul_load_sequencer_pkg::*;
#(
  parameter int LATENCY = BRAM_RD_LATENCY
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this small array is reset on purpose: a tag left in flight after an abort would raise a stray valid.
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= RD_TAG_NONE;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[LATENCY-1];

endmodule

// File: rtl/poly_mul_load_sequencer.sv
// Drives the shared BRAM read port: secret words first, then public words under
// multiplier backpressure, then a one-cycle done pulse. All outputs are registered.
module poly_mul_load_sequencer
  import poly_mul_load_sequencer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  poly_mul_load_sequencer_if.slave   ctrl
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] s_base_q;
  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q;
  phase_e            phase_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] s_addr_d;
  logic [ADDR_W-1:0] a_addr_d;
  logic              s_last_d;
  logic              a_last_d;

  // Addresses wrap modulo 2^ADDR_W by construction of the adder width.
  assign s_addr_d = s_base_q + ADDR_W'(cnt_q);
  assign a_addr_d = a_base_q + ADDR_W'(cnt_q);
  assign s_last_d = (cnt_q == CNT_W'(S_WORDS - 1));
  assign a_last_d = (cnt_q == CNT_W'(A_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s_base_q <= '0;
      a_base_q <= '0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      phase_q  <= PH_S;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: pulse outputs get a default here; a later non-blocking write in the case wins, so they self-clear.
      rd_en_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      if (done_q) busy_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // busy_q is still high during the done cycle, which is what rejects a start there.
          if (ctrl.start && !busy_q) begin
            s_base_q <= ctrl.s_base;
            a_base_q <= ctrl.a_base;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= LOAD_S;
          end
        end
        LOAD_S: begin
          rd_en_q <= 1'b1;
          addr_q  <= s_addr_d;
          phase_q <= PH_S;
          last_q  <= s_last_d;
          if (s_last_d) begin
            cnt_q   <= '0;
            state_q <= STREAM_A;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STREAM_A: begin
          if (ctrl.mul_ready) begin
            rd_en_q <= 1'b1;
            addr_q  <= a_addr_d;
            phase_q <= PH_A;
            if (a_last_d) begin
              cnt_q   <= '0;
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DRAIN: state_q <= DONE;
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rd_tag_t issue_tag;
  rd_tag_t ret_tag;

  assign issue_tag = '{valid: rd_en_q, phase: phase_q, last: last_q};

  bram_rd_valid_pipe #(.LATENCY(BRAM_RD_LATENCY)) u_valid_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (issue_tag),
    .tag_o (ret_tag)
  );

  assign ctrl.bram_addr    = addr_q;
  assign ctrl.bram_rd_en   = rd_en_q;
  assign ctrl.s_load_valid = ret_tag.valid && (ret_tag.phase == PH_S);
  assign ctrl.s_load_done  = ret_tag.valid && (ret_tag.phase == PH_S) && ret_tag.last;
  assign ctrl.a_valid      = ret_tag.valid && (ret_tag.phase == PH_A);
  assign ctrl.busy         = busy_q;
  assign ctrl.done         = done_q;

endmodule
